pl2ps_capture_sched: RTL

//  Capture scheduler ahead of the PL->PS DMA0 stream muxer. Round-robins over the enabled sources (rdm/adc/ch0..ch5).

---
 rtl/pl2ps_capture_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pl2ps_capture_sched.sv
// Capture scheduler for the PL->PS DMA0 stream muxer: round-robins enabled sources,
// captures N CPIs per source and gates the selected stream into the CDC FIFO.
module pl2ps_capture_sched #(
    parameter int DATA_W = 32,
    parameter int SRC_N  = 8,
    parameter int WCNT_W = 16,
    parameter int CPI_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic [SRC_N-1:0]  cfg_src_mask,
    input  logic [CPI_W-1:0]  cfg_cpi_per_src,
    input  logic [WCNT_W-1:0] cfg_max_words,
    input  logic              cpib,
    input  logic              cpie,
    input  logic [DATA_W-1:0] in_tdata,
    input  logic              in_tvalid,
    input  logic              fifo_full,
    output logic [7:0]        mux_sel,
    output logic [DATA_W-1:0] out_tdata,
    output logic              out_tvalid,
    output logic              out_tlast,
    output logic              busy,
    output logic              round_done,
    output logic              ovf_sticky,
    output logic [2:0]        dbg_state
);

    // Stream contract: in_tvalid carries one beat per cycle with no backpressure;
    // out_tvalid is a one-cycle write strobe and out_tlast is only valid alongside it.
    localparam int SRC_W = (SRC_N > 1) ? $clog2(SRC_N) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PICK  = 3'd1,
        S_ARM   = 3'd2,
        S_CAPT  = 3'd3,
        S_FLUSH = 3'd4,
        S_END   = 3'd5
    } state_t;

    state_t              state;
    logic [SRC_W-1:0]    cur_src;
    logic [CPI_W-1:0]    cpi_cnt;
    logic [WCNT_W-1:0]   word_cnt;
    logic [DATA_W-1:0]   hold;
    logic                hold_v;

    logic [SRC_W-1:0]    pick_idx;
    logic                pick_found;
    logic [CPI_W-1:0]    cpi_target;
    logic [CPI_W-1:0]    cpi_cnt_nx;
    logic [WCNT_W-1:0]   word_cnt_nx;
    logic                max_hit;

    // Nearest enabled source above cur_src with wrap; descending loop lets the closest win.
    always_comb begin
        pick_idx   = cur_src;
        pick_found = 1'b0;
        for (int i = SRC_N; i >= 1; i--) begin
            if (cfg_src_mask[(int'(cur_src) + i) % SRC_N]) begin
                pick_idx   = SRC_W'((int'(cur_src) + i) % SRC_N);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        cpi_target  = (cfg_cpi_per_src == '0) ? CPI_W'(1) : cfg_cpi_per_src;
        cpi_cnt_nx  = cpi_cnt + 1'b1;
        word_cnt_nx = word_cnt + 1'b1;
        max_hit     = (cfg_max_words != '0) && (word_cnt_nx == cfg_max_words);
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cur_src    <= SRC_W'(SRC_N - 1);
            mux_sel    <= 8'd0;
            cpi_cnt    <= '0;
            word_cnt   <= '0;
            hold       <= '0;
            hold_v     <= 1'b0;
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            round_done <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            round_done <= 1'b0;

            if (out_tvalid && fifo_full) begin
                ovf_sticky <= 1'b1;
            end else if (state == S_IDLE && !cfg_en) begin
                ovf_sticky <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (cfg_en && (cfg_src_mask != '0)) begin
                        state <= S_PICK;
                    end
                end
                S_PICK: begin
                    // The mask may have been cleared while running; fall back to IDLE then.
                    if (pick_found) begin
                        cur_src    <= pick_idx;
                        mux_sel    <= 8'(pick_idx);
                        cpi_cnt    <= '0;
                        round_done <= (pick_idx <= cur_src);
                        state      <= S_ARM;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ARM: begin
                    if (!cfg_en) begin
                        state <= S_IDLE;
                    end else if (cpib) begin
                        word_cnt <= '0;
                        hold_v   <= 1'b0;
                        state    <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    if (in_tvalid) begin
                        word_cnt <= word_cnt_nx;
                        if (hold_v) begin
                            out_tdata  <= hold;
                            out_tvalid <= 1'b1;
                        end
                        hold   <= in_tdata;
                        hold_v <= 1'b1;
                    end
                    // Hitting the word limit closes the packet exactly like cpie would.
                    if ((in_tvalid && max_hit) || cpie) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (hold_v) begin
                        out_tdata  <= hold;
                        out_tvalid <= 1'b1;
                        out_tlast  <= 1'b1;
                        hold_v     <= 1'b0;
                    end
                    state <= S_END;
                end
                S_END: begin
                    cpi_cnt <= cpi_cnt_nx;
                    if (!cfg_en) begin
                        state <= S_IDLE;
                    end else if (cpi_cnt_nx >= cpi_target) begin
                        state <= S_PICK;
                    end else begin
                        state <= S_ARM;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
